// File: rtl/sift_edge_test.sv
// SIFT edge-response test: keeps a keypoint when tr^2*r < (r+1)^2*det and det > 0.
// Four-stage pipeline stalled as a whole by iready, plus saturating kept/rejected counters.
module sift_edge_test #(
  parameter int DW = 10,
  parameter int TW = 4,
  parameter int CW = 16
) (
  input  logic                    iclk,
  input  logic                    irst_n,
  input  logic                    ivalid,
  output logic                    oready,
  input  logic [DW-1:0]           idxx,
  input  logic [DW-1:0]           idyy,
  input  logic [DW-1:0]           idxy,
  input  logic [TW-1:0]           icurv_thr,
  output logic                    ovalid,
  input  logic                    iready,
  output logic                    okeep,
  output logic [2*DW+TW+1:0]      oleft_value,
  output logic [2*DW+2*TW+2:0]    oright_value,
  output logic [2*DW:0]           odet,
  input  logic                    iclr,
  output logic [CW-1:0]           okept_cnt,
  output logic [CW-1:0]           orej_cnt
);

  localparam int LW   = 2*DW+TW+2;
  localparam int RW   = 2*DW+2*TW+3;
  localparam int DETW = 2*DW+1;
  localparam int TRW  = DW+1;
  localparam int PW   = 2*DW;
  localparam int T2W  = 2*DW+2;
  localparam int RSW  = 2*TW+2;

  logic en;
  assign en     = iready;
  assign oready = iready;

  // Stage 1: trace and the two determinant products
  logic signed [DW-1:0]  dxx_s, dyy_s, dxy_s;
  logic signed [TRW-1:0] tr_d;
  logic signed [PW-1:0]  pxx_d, pxy_d;

  assign dxx_s = idxx;
  assign dyy_s = idyy;
  assign dxy_s = idxy;
  assign tr_d  = TRW'(dxx_s) + TRW'(dyy_s);
  assign pxx_d = PW'(dxx_s) * PW'(dyy_s);
  assign pxy_d = PW'(dxy_s) * PW'(dxy_s);

  logic                  s1_valid;
  logic signed [TRW-1:0] s1_tr;
  logic signed [PW-1:0]  s1_pxx, s1_pxy;
  logic [TW-1:0]         s1_r;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      s1_valid <= 1'b0;
      s1_tr    <= '0;
      s1_pxx   <= '0;
      s1_pxy   <= '0;
      s1_r     <= '0;
    end else if (en) begin
      s1_valid <= ivalid;
      s1_tr    <= tr_d;
      s1_pxx   <= pxx_d;
      s1_pxy   <= pxy_d;
      s1_r     <= icurv_thr;
    end
  end

  // Stage 2: trace squared and determinant
  logic signed [T2W-1:0]  tr2_d;
  logic signed [DETW-1:0] det_d;

  assign tr2_d = T2W'(s1_tr) * T2W'(s1_tr);
  assign det_d = DETW'(s1_pxx) - DETW'(s1_pxy);

  logic                   s2_valid;
  logic signed [T2W-1:0]  s2_tr2;
  logic signed [DETW-1:0] s2_det;
  logic [TW-1:0]          s2_r;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      s2_valid <= 1'b0;
      s2_tr2   <= '0;
      s2_det   <= '0;
      s2_r     <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_tr2   <= tr2_d;
      s2_det   <= det_d;
      s2_r     <= s1_r;
    end
  end

  // Stage 3: left side tr^2*r and the (r+1)^2 scale for the right side
  logic signed [TW:0]    r_s;
  logic signed [LW-1:0]  left_d;
  logic [RSW-1:0]        rp1;
  logic [RSW-1:0]        rs_d;

  assign r_s    = {1'b0, s2_r};
  assign left_d = LW'(s2_tr2) * LW'(r_s);
  assign rp1    = RSW'(s2_r) + RSW'(1);
  assign rs_d   = rp1 * rp1;

  logic                   s3_valid;
  logic signed [LW-1:0]   s3_left;
  logic [RSW-1:0]         s3_rs;
  logic signed [DETW-1:0] s3_det;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      s3_valid <= 1'b0;
      s3_left  <= '0;
      s3_rs    <= '0;
      s3_det   <= '0;
    end else if (en) begin
      s3_valid <= s2_valid;
      s3_left  <= left_d;
      s3_rs    <= rs_d;
      s3_det   <= det_d_hold(s2_det);
    end
  end

  function automatic logic signed [DETW-1:0] det_d_hold(input logic signed [DETW-1:0] d);
    return d;
  endfunction

  // Stage 4: right side and decision; equality and non-positive det both reject
  logic signed [RSW:0]  rs_s;
  logic signed [RW-1:0] right_d;
  logic                 keep_d;

  assign rs_s    = {1'b0, s3_rs};
  assign right_d = RW'(s3_det) * RW'(rs_s);
  assign keep_d  = (s3_det > DETW'(0)) && (RW'(s3_left) < right_d);

  // Output data only moves on a valid result so it holds while ovalid is low
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      ovalid       <= 1'b0;
      okeep        <= 1'b0;
      oleft_value  <= '0;
      oright_value <= '0;
      odet         <= '0;
    end else if (en) begin
      ovalid <= s3_valid;
      if (s3_valid) begin
        okeep        <= keep_d;
        oleft_value  <= s3_left;
        oright_value <= right_d;
        odet         <= s3_det;
      end
    end
  end

  logic xfer_out;
  assign xfer_out = ovalid && iready;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      okept_cnt <= '0;
      orej_cnt  <= '0;
    end else if (iclr) begin
      okept_cnt <= '0;
      orej_cnt  <= '0;
    end else if (xfer_out) begin
      if (okeep) begin
        if (okept_cnt != '1) okept_cnt <= okept_cnt + CW'(1);
      end else begin
        if (orej_cnt != '1) orej_cnt <= orej_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sift_edge_test.sv
// Directed bench for sift_edge_test: hand-computed vectors, stall/order, saturation, clear, reset.
module tb_sift_edge_test;
  localparam int DW = 10;
  localparam int TW = 4;
  localparam int CW = 4;

  logic iclk = 1'b0;
  logic irst_n, ivalid, iready, iclr, oready, ovalid, okeep;
  logic [DW-1:0] idxx, idyy, idxy;
  logic [TW-1:0] icurv_thr;
  logic [2*DW+TW+1:0] oleft_value;
  logic [2*DW+2*TW+2:0] oright_value;
  logic [2*DW:0] odet;
  logic [CW-1:0] okept_cnt, orej_cnt;

  int n_checks = 0;
  int n_fail = 0;
  int exp_kept = 0;
  int exp_rej = 0;
  int str_got = 0;

  sift_edge_test #(.DW(DW), .TW(TW), .CW(CW)) dut (
    .iclk(iclk), .irst_n(irst_n), .ivalid(ivalid), .oready(oready),
    .idxx(idxx), .idyy(idyy), .idxy(idxy), .icurv_thr(icurv_thr),
    .ovalid(ovalid), .iready(iready), .okeep(okeep),
    .oleft_value(oleft_value), .oright_value(oright_value), .odet(odet),
    .iclr(iclr), .okept_cnt(okept_cnt), .orej_cnt(orej_cnt)
  );

  always #5 iclk = ~iclk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int dxx, input int dyy, input int dxy, input int r);
    idxx = 10'(dxx);
    idyy = 10'(dyy);
    idxy = 10'(dxy);
    icurv_thr = 4'(r);
  endtask

  task automatic count_out(input bit keep);
    if (keep) begin
      if (exp_kept < 15) exp_kept++;
    end else begin
      if (exp_rej < 15) exp_rej++;
    end
  endtask

  task automatic run_vec(input string tag, input int dxx, input int dyy, input int dxy, input int r,
                         input longint e_det, input longint e_left, input longint e_right,
                         input bit e_keep);
    int lat;
    set_in(dxx, dyy, dxy, r);
    ivalid = 1'b1;
    @(posedge iclk); #1;
    ivalid = 1'b0;
    lat = 1;
    while (!ovalid && lat < 10) begin
      @(posedge iclk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, 4);
    chk({tag, "_det"}, $signed(odet), e_det);
    chk({tag, "_left"}, $signed(oleft_value), e_left);
    chk({tag, "_right"}, $signed(oright_value), e_right);
    chk({tag, "_keep"}, okeep, e_keep);
    count_out(e_keep);
    @(posedge iclk); #1;
    chk({tag, "_vdrop"}, ovalid, 0);
    chk({tag, "_hold"}, $signed(odet), e_det);
    chk({tag, "_kept"}, okept_cnt, exp_kept);
    chk({tag, "_rej"}, orej_cnt, exp_rej);
  endtask

  initial begin
    int seen;
    irst_n = 1'b0; ivalid = 1'b0; iready = 1'b1; iclr = 1'b0;
    set_in(0, 0, 0, 0);
    repeat (3) @(posedge iclk);
    #1;
    chk("rst_ovalid", ovalid, 0);
    chk("rst_okeep", okeep, 0);
    chk("rst_det", odet, 0);
    chk("rst_kept", okept_cnt, 0);
    chk("rst_rej", orej_cnt, 0);
    chk("oready_hi", oready, 1);
    irst_n = 1'b1;
    @(posedge iclk); #1;

    run_vec("pass", 3, 3, 0, 10, 9, 360, 1089, 1);
    run_vec("equal", 10, 1, 0, 10, 10, 1210, 1210, 0);
    run_vec("negdet", 2, -2, 0, 10, -4, 0, -484, 0);
    run_vec("ext1", -512, -512, -512, 15, 0, 15728640, 0, 0);
    run_vec("ext2", -512, 511, -512, 15, -523776, 15, -134086656, 0);
    run_vec("r0", 3, 3, 0, 0, 9, 0, 9, 1);
    run_vec("rej", 3, 3, 2, 1, 5, 36, 20, 0);

    // Stream of 8 with a 3-cycle stall before sample 4
    fork
      begin
        int i = 0;
        bit stalled = 0;
        while (i < 8) begin
          set_in(i + 1, i + 1, 0, 10);
          ivalid = 1'b1;
          if (i == 4 && !stalled) begin
            iready = 1'b0;
            #1 chk("oready_lo", oready, 0);
            repeat (3) @(posedge iclk);
            #1;
            iready = 1'b1;
            stalled = 1;
          end
          @(posedge iclk); #1;
          i++;
        end
        ivalid = 1'b0;
      end
      begin
        logic [2*DW:0] p_det;
        logic [2*DW+TW+1:0] p_left;
        logic p_valid, p_keep;
        bit p_stall = 0;
        repeat (30) begin
          @(negedge iclk);
          if (!iready && p_stall) begin
            chk("stall_valid", ovalid, p_valid);
            chk("stall_det", odet, p_det);
            chk("stall_left", oleft_value, p_left);
            chk("stall_keep", okeep, p_keep);
          end
          if (ovalid && iready) begin
            chk("str_det", $signed(odet), (str_got + 1) * (str_got + 1));
            chk("str_left", $signed(oleft_value), 40 * (str_got + 1) * (str_got + 1));
            str_got++;
            count_out(1'b1);
          end
          p_stall = !iready;
          p_det = odet; p_left = oleft_value; p_valid = ovalid; p_keep = okeep;
        end
      end
    join
    chk("str_count", str_got, 8);
    chk("str_kept", okept_cnt, exp_kept);
    chk("str_sum", okept_cnt + orej_cnt, 15);

    // Saturation: 20 more passing samples
    set_in(3, 3, 0, 10);
    ivalid = 1'b1;
    repeat (20) begin
      @(posedge iclk); #1;
    end
    ivalid = 1'b0;
    repeat (6) @(posedge iclk);
    #1;
    chk("sat_kept", okept_cnt, 15);
    chk("sat_rej", orej_cnt, 5);

    // Clear coinciding with a rejecting output transfer
    set_in(2, -2, 0, 10);
    ivalid = 1'b1;
    @(posedge iclk); #1;
    ivalid = 1'b0;
    seen = 0;
    while (!ovalid && seen < 10) begin
      @(posedge iclk); #1;
      seen++;
    end
    chk("clr_valid", ovalid, 1);
    iclr = 1'b1;
    @(posedge iclk); #1;
    iclr = 1'b0;
    chk("clr_kept", okept_cnt, 0);
    chk("clr_rej", orej_cnt, 0);

    // Reset mid-stream
    for (int k = 0; k < 3; k++) begin
      set_in(k + 1, k + 1, 0, 10);
      ivalid = 1'b1;
      @(posedge iclk); #1;
    end
    ivalid = 1'b0;
    @(posedge iclk); #1;
    chk("mid_valid", ovalid, 1);
    irst_n = 1'b0;
    #1;
    chk("mid_rst_valid", ovalid, 0);
    chk("mid_rst_det", odet, 0);
    chk("mid_rst_keep", okeep, 0);
    @(posedge iclk); #1;
    irst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge iclk); #1;
      if (ovalid) seen++;
    end
    chk("no_stale", seen, 0);
    chk("post_rst_kept", okept_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sift_edge_test.md
# sift_edge_test

Parametrised SIFT edge-response (principal-curvature) test for the keypoint detection path. It accepts one Hessian triple (Dxx, Dyy, Dxy) per transfer and computes trace and determinant internally. It evaluates tr²·r < (r+1)²·det against a per-sample curvature threshold r and emits a keep/reject flag with the intermediate values. It sits after the DoG extremum/Hessian stage and before keypoint output, and keeps saturating statistics counters for kept and rejected candidates.

## Interface
Parameters:
- DW, 10: signed width of each Hessian element.
- TW, 4: unsigned width of the curvature threshold r.
- CW, 16: width of the kept/rejected statistics counters.

Derived widths (localparams):
- LW = 2·DW+TW+2
- RW = 2·DW+2·TW+3
- DETW = 2·DW+1

Ports:
- iclk  in  1  clock.
- irst_n  in  1  reset, asynchronous, active-low.
- ivalid  in  1  input triple valid.
- oready  out  1  input may be accepted; combinationally equal to iready.
- idxx, idyy, idxy  in  DW each  signed Hessian elements.
- icurv_thr  in  TW  unsigned r, sampled with the triple.
- ovalid  out  1  result valid.
- iready  in  1  downstream ready; global pipeline enable.
- okeep  out  1  1 = candidate passes the edge test.
- oleft_value  out  LW  signed tr²·r.
- oright_value  out  RW  signed (r+1)²·det.
- odet  out  DETW  signed determinant.
- iclr  in  1  synchronous clear of the statistics counters.
- okept_cnt, orej_cnt  out  CW each  saturating counters.

## Operation
- Transfer in: ivalid && iready. Transfer out: ovalid && iready.
- Pipeline enable is en = iready. When en is 0, every stage register, including valid bits, holds. No bubble collapsing.
- Data registers load only when en is 1. The valid bit of each stage propagates with en. Data of invalid stages is don't-care internally, but the outputs hold their last valid value when ovalid is 0.
- S1 registers:
  - tr = dxx+dyy (DW+1 bits)
  - pxx = dxx·dyy (2·DW bits)
  - pxy = dxy·dxy (2·DW bits)
  - r (TW bits)
  - valid
- S2 registers:
  - tr2 = tr·tr (2·DW+2 bits, non-negative)
  - det = pxx−pxy (DETW bits)
  - r, valid
- S3 registers:
  - left = tr2·r
  - rs = (r+1)², unsigned, 2·TW+2 bits
  - det, valid
- S4 registers:
  - oleft_value = left
  - oright_value = rs·det, signed multiply with rs zero-extended
  - odet = det
  - okeep = (det > 0) && (left < right)
  - ovalid
- Equality left == right rejects. det ≤ 0 always rejects.
- All arithmetic is full-precision sign-extended; no truncation or saturation at the stated widths for any input combination.
- r = 0 is legal: left = 0, and keep reduces to det > 0.
- Counters:
  - On an output transfer, okept_cnt increments if okeep is 1; otherwise orej_cnt increments.
  - Both counters saturate at 2^CW−1.
  - iclr forces both to 0 and wins over a simultaneous increment.
- Reset: all stage registers, valid bits, outputs and counters go to 0. ovalid = 0, okeep = 0.
- Reset mid-stream discards all in-flight samples; there is no output for them.

## Timing
- Latency is 4 enabled cycles from input transfer to ovalid with the corresponding result.
- Throughput is 1 sample per cycle while iready = 1.
- oready has no register; upstream must treat oready = iready.
- Stall of N cycles adds exactly N cycles of latency to every in-flight sample. Order is preserved, with no duplicates and no drops.
- While stalled, ovalid, okeep, oleft_value, oright_value and odet remain stable.
- Counter outputs are registered and update the cycle after the output transfer.

## Test plan
- Pass case: dxx=3, dyy=3, dxy=0, r=10 → 4 cycles later ovalid=1, odet=9, oleft=360, oright=1089, okeep=1; okept_cnt becomes 1.
- Equality rejects: dxx=10, dyy=1, dxy=0, r=10 → oleft=1210, oright=1210, okeep=0; orej_cnt increments.
- Negative determinant: dxx=2, dyy=−2, dxy=0, r=10 → odet=−4, oleft=0, oright=−484, okeep=0.
- Width extremes: dxx=dyy=dxy=−512, r=15 (DW=10, TW=4) → odet=0, oleft=15728640, oright=0, okeep=0. Also dxx=−512, dyy=511, dxy=−512 → odet=−523776 with no overflow.
- Back-to-back stream of 8 samples with iready low for 3 cycles mid-stream → outputs frozen during the stall, and all 8 results appear in order exactly once. Counter sum is 8.
- Counters: CW=4, feed 20 passing samples → okept_cnt saturates at 15. Then assert iclr in the same cycle as an output transfer → both counters read 0. Also assert irst_n low mid-stream → ovalid=0 immediately, and no stale results emerge after reset release.
